icache_nway: RTL and testbench
==============================

Name: icache_nway

Overview:
- Parametrised N-way set-associative, read-only instruction cache.
- Sits between the fetch stage (single-word ibus-style handshake) and the cbus refill port.
- Adds configurable ways, sets and line length, tree-PLRU replacement, line-aligned burst refill, and a separate invalidate channel (index and hit modes).

Parameters:
- WAYS, 4, associativity; power of 2, range 2..8.
- SETS, 64, number of sets; power of 2.
- WORDS_PER_LINE, 8, 32-bit words per line; power of 2, range 4..16.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- req_valid  in  1  fetch request valid
- req_addr  in  32  fetch byte address; bits [1:0] ignored
- addr_ok  out  1  request accepted this cycle
- data_ok  out  1  rdata valid
- rdata  out  32  fetched word
- inv_valid  in  1  invalidate request
- inv_hit  in  1  1 = hit-invalidate, 0 = index-invalidate
- inv_addr  in  32  invalidate address; in index mode the way is taken from the bits directly above the index
- inv_done  out  1  invalidate completed
- creq_valid  out  1  refill request
- creq_addr  out  32  line-aligned refill address
- creq_len  out  4  burst length minus 1, = WORDS_PER_LINE-1
- cresp_ready  in  1  cresp_data valid this cycle
- cresp_last  in  1  last beat of the burst
- cresp_data  in  32  refill word

Behaviour:
- Address split: offset = log2(WORDS_PER_LINE) bits above [1:0]; index = log2(SETS) bits above offset; tag = the remaining upper bits.
- Storage:
  - valid bits and PLRU bits are flops, cleared asynchronously while resetn=0.
  - tags are in a combinational-read array.
  - data is in a 1-cycle-read RAM.
- Reset values: all outputs 0, state IDLE. Asserting resetn mid-refill aborts the burst; no partially filled line may become valid.
- FSM states: IDLE, REFILL.
- IDLE behaviour:
  - inv_valid has priority over req_valid. An invalidate clears the selected way's valid bit, pulses inv_done for 1 cycle, and holds addr_ok=0 that cycle.
  - A hit-invalidate that misses still pulses inv_done and changes nothing.
  - req_valid with a hit (no invalidate this cycle): addr_ok=1 combinationally. Next cycle data_ok=1 with the word. The hit way's PLRU path is updated.
  - req_valid with a miss: addr_ok=0. Capture victim way, then go to REFILL.
  - Victim selection: the lowest-numbered invalid way if one exists, otherwise the tree-PLRU victim.
- REFILL behaviour:
  - creq_valid=1; creq_addr = {tag, index, 0}; creq_len constant.
  - Each cresp_ready beat writes to the victim way at an offset counter that starts at 0 and increments per beat.
  - While the line fills, the victim's valid bit is 0.
  - On a beat with cresp_last: write the tag, set valid, update PLRU toward the victim, clear the counter, return to IDLE.
  - The pending request re-looks-up and hits on the next cycle; the requester holds req_valid/req_addr stable until addr_ok.
- During REFILL: addr_ok=0, inv_done=0, and inv_valid is ignored (the requester holds it).
- No cresp_ready while IDLE is legal; such beats are ignored.
- data_ok is never asserted without a prior addr_ok. Exactly one data_ok per addr_ok.
- Back-to-back hits sustain 1 word/cycle.
- Tree PLRU: WAYS-1 bits per set. An access sets each node to point away from the accessed way.

Test Plan:
- Reset, then fetch 0x1000 (miss): creq_addr=0x1000, creq_len=7. Feed 8 beats of 0xA0..0xA7. Next cycle addr_ok=1; following cycle data_ok=1, rdata=0xA0.
- Consecutive fetches 0x1000, 0x1004, ... 0x101C after the fill: addr_ok every cycle, 8 data_ok pulses, rdata 0xA0..0xA7 in order, no creq_valid.
- Fill 5 distinct tags into set 0 (WAYS=4), accessing the lines in order A, B, C, D, then re-touch A, then fetch E: E replaces B, and A is still a hit.
- Hit-invalidate 0x1000 concurrent with req_valid: inv_done=1, addr_ok=0. A subsequent fetch of 0x1000 misses and refills.
- Drop resetn after 3 refill beats: creq_valid=0 immediately. After release, fetch the same address: it misses, with creq_addr equal to the original line address.
- Index-invalidate of an empty set, and hit-invalidate that misses: inv_done pulses, no state change; other lines still hit.

Source files
------------

// File: rtl/icache_nway.sv
// N-way set-associative read-only instruction cache with tree-PLRU replacement,
// line-burst refill over cbus and an index/hit invalidate channel.
module icache_nway #(
  parameter int unsigned WAYS           = 4,
  parameter int unsigned SETS           = 64,
  parameter int unsigned WORDS_PER_LINE = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  input  logic        inv_valid,
  input  logic        inv_hit,
  input  logic [31:0] inv_addr,
  output logic        inv_done,
  output logic        creq_valid,
  output logic [31:0] creq_addr,
  output logic [3:0]  creq_len,
  input  logic        cresp_ready,
  input  logic        cresp_last,
  input  logic [31:0] cresp_data
);

  localparam int unsigned OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned WAY_W  = $clog2(WAYS);
  localparam int unsigned TAG_W  = 30 - OFF_W - IDX_W;
  localparam int unsigned PLRU_W = WAYS - 1;
  localparam int unsigned DEPTH  = WAYS * SETS * WORDS_PER_LINE;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t r_state, w_state_nxt;

  logic [SETS-1:0][WAYS-1:0]   r_valid;
  logic [SETS-1:0][PLRU_W-1:0] r_plru;
  logic [TAG_W-1:0]            r_tag  [SETS][WAYS];
  logic [31:0]                 r_data [DEPTH];

  logic [TAG_W-1:0] r_miss_tag;
  logic [IDX_W-1:0] r_miss_idx;
  logic [WAY_W-1:0] r_victim;
  logic [OFF_W-1:0] r_cnt;

  logic [OFF_W-1:0] w_req_off;
  logic [IDX_W-1:0] w_req_idx, w_inv_idx;
  logic [TAG_W-1:0] w_req_tag, w_inv_tag;
  logic             w_hit, w_free, w_inv_lookup, w_inv_match;
  logic [WAY_W-1:0] w_hit_way, w_free_way, w_inv_lookup_way, w_inv_way, w_victim;
  logic             w_miss, w_beat, w_fill_last;
  logic             w_unused;

  assign w_req_off = req_addr[2 +: OFF_W];
  assign w_req_idx = req_addr[2 + OFF_W +: IDX_W];
  assign w_req_tag = req_addr[31 -: TAG_W];
  assign w_inv_idx = inv_addr[2 + OFF_W +: IDX_W];
  assign w_inv_tag = inv_addr[31 -: TAG_W];
  assign w_unused  = ^{req_addr[1:0], inv_addr[1 + OFF_W:0]};

  // Tree PLRU whose root splits on the way LSB; node for level l sits at (2^l-1) + way mod 2^l.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
    logic [WAY_W-1:0] v;
    logic             m;
    v = '0;
    for (int w = 0; w < WAYS; w++) begin
      m = 1'b1;
      for (int l = 0; l < WAY_W; l++)
        if (bits[(1 << l) - 1 + (w % (1 << l))] != w[l]) m = 1'b0;
      if (m) v = WAY_W'(w);
    end
    return v;
  endfunction

  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                   input logic [WAY_W-1:0]  aw);
    logic [PLRU_W-1:0] nb;
    nb = bits;
    for (int w = 0; w < WAYS; w++)
      if (aw == WAY_W'(w))
        for (int l = 0; l < WAY_W; l++)
          nb[(1 << l) - 1 + (w % (1 << l))] = ~aw[l];
    return nb;
  endfunction

  // Tag compare for fetch and hit-invalidate; lowest-numbered free way wins.
  always_comb begin
    w_hit            = 1'b0;
    w_hit_way        = '0;
    w_free           = 1'b0;
    w_free_way       = '0;
    w_inv_lookup     = 1'b0;
    w_inv_lookup_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_req_idx][w] && (r_tag[w_req_idx][w] == w_req_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
      if (!r_valid[w_req_idx][w]) begin
        w_free     = 1'b1;
        w_free_way = WAY_W'(w);
      end
      if (r_valid[w_inv_idx][w] && (r_tag[w_inv_idx][w] == w_inv_tag)) begin
        w_inv_lookup     = 1'b1;
        w_inv_lookup_way = WAY_W'(w);
      end
    end
  end

  assign w_victim    = w_free ? w_free_way : plru_victim(r_plru[w_req_idx]);
  assign w_inv_match = inv_hit ? w_inv_lookup : 1'b1;
  assign w_inv_way   = inv_hit ? w_inv_lookup_way : inv_addr[2 + OFF_W + IDX_W +: WAY_W];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    addr_ok     = 1'b0;
    inv_done    = 1'b0;
    creq_valid  = 1'b0;
    w_miss      = 1'b0;
    w_beat      = 1'b0;
    w_fill_last = 1'b0;
    case (r_state)
      IDLE: begin
        if (inv_valid) begin
          inv_done = 1'b1;
        end else if (req_valid) begin
          if (w_hit) begin
            addr_ok = 1'b1;
          end else begin
            w_miss      = 1'b1;
            w_state_nxt = REFILL;
          end
        end
      end
      REFILL: begin
        creq_valid = 1'b1;
        if (cresp_ready) begin
          w_beat = 1'b1;
          if (cresp_last) begin
            w_fill_last = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign creq_addr = creq_valid ? {r_miss_tag, r_miss_idx, {(OFF_W + 2){1'b0}}} : 32'h0;
  assign creq_len  = creq_valid ? 4'(WORDS_PER_LINE - 1) : 4'h0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_miss_tag <= '0;
      r_miss_idx <= '0;
      r_victim   <= '0;
      r_cnt      <= '0;
    end else begin
      if (w_miss) begin
        r_miss_tag <= w_req_tag;
        r_miss_idx <= w_req_idx;
        r_victim   <= w_victim;
      end
      if (w_fill_last)  r_cnt <= '0;
      else if (w_beat)  r_cnt <= r_cnt + OFF_W'(1);
    end
  end

  // Victim is invalidated at miss time so a half-filled line can never hit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid <= '0;
      r_plru  <= '0;
    end else begin
      if (inv_done && w_inv_match) r_valid[w_inv_idx][w_inv_way] <= 1'b0;
      if (w_miss)                  r_valid[w_req_idx][w_victim]  <= 1'b0;
      if (w_fill_last) begin
        r_valid[r_miss_idx][r_victim] <= 1'b1;
        r_plru[r_miss_idx] <= plru_touch(r_plru[r_miss_idx], r_victim);
      end
      if (addr_ok) r_plru[w_req_idx] <= plru_touch(r_plru[w_req_idx], w_hit_way);
    end
  end

  always_ff @(posedge clk) begin
    if (w_beat)      r_data[{r_victim, r_miss_idx, r_cnt}] <= cresp_data;
    if (w_fill_last) r_tag[r_miss_idx][r_victim]           <= r_miss_tag;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_ok <= 1'b0;
      rdata   <= '0;
    end else begin
      data_ok <= addr_ok;
      if (addr_ok) rdata <= r_data[{w_hit_way, w_req_idx, w_req_off}];
    end
  end

endmodule

// File: tb/tb_icache_nway.sv
// Directed self-checking bench for icache_nway (WAYS=4, SETS=64, WORDS_PER_LINE=8).
module tb_icache_nway;

  localparam int WPL = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;
  logic        inv_valid, inv_hit;
  logic [31:0] inv_addr;
  logic        inv_done;
  logic        creq_valid;
  logic [31:0] creq_addr;
  logic [3:0]  creq_len;
  logic        cresp_ready, cresp_last;
  logic [31:0] cresp_data;

  int checks = 0;
  int errors = 0;

  logic        s_req, s_ok, s_tmo;
  logic [31:0] s_addr, s_data;
  logic [3:0]  s_len;
  int          s_lat;

  icache_nway #(.WAYS(4), .SETS(64), .WORDS_PER_LINE(8)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_addr(req_addr), .addr_ok(addr_ok),
    .data_ok(data_ok), .rdata(rdata),
    .inv_valid(inv_valid), .inv_hit(inv_hit), .inv_addr(inv_addr), .inv_done(inv_done),
    .creq_valid(creq_valid), .creq_addr(creq_addr), .creq_len(creq_len),
    .cresp_ready(cresp_ready), .cresp_last(cresp_last), .cresp_data(cresp_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic apply_reset();
    @(negedge clk);
    resetn = 1'b0; req_valid = 1'b0; req_addr = '0; inv_valid = 1'b0; inv_hit = 1'b0;
    inv_addr = '0; cresp_ready = 1'b0; cresp_last = 1'b0; cresp_data = '0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  // Fetch one word, serving any refill burst with base+beat; reports what the bus saw.
  task automatic fetch(input logic [31:0] a, input logic [31:0] base,
                       output logic seen_req, output logic [31:0] seen_addr,
                       output logic [3:0] seen_len, output int lat,
                       output logic got_ok, output logic [31:0] got_data, output logic tmo);
    int beat, last_c;
    beat = 0; last_c = -1; seen_req = 1'b0; seen_addr = '0; seen_len = '0; lat = -1; tmo = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a;
    for (int c = 0; c < 64 && tmo; c++) begin
      #1;
      cresp_ready = 1'b0; cresp_last = 1'b0;
      if (addr_ok) begin
        tmo = 1'b0;
        lat = c - last_c;
      end else begin
        if (creq_valid) begin
          seen_req = 1'b1; seen_addr = creq_addr; seen_len = creq_len;
          cresp_ready = 1'b1; cresp_data = base + 32'(beat); cresp_last = (beat == WPL - 1);
          if (beat == WPL - 1) last_c = c;
          beat++;
        end
        @(negedge clk);
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    got_ok = data_ok; got_data = rdata;
  endtask

  task automatic test_reset();
    resetn = 1'b0; req_valid = 1'b0; req_addr = '0; inv_valid = 1'b0; inv_hit = 1'b0;
    inv_addr = '0; cresp_ready = 1'b0; cresp_last = 1'b0; cresp_data = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if ({addr_ok, data_ok, inv_done, creq_valid} !== 4'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {addr_ok, data_ok, inv_done, creq_valid}); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    checks++; if ({creq_addr, creq_len} !== 36'h0) begin
      errors++; $display("FAIL reset_creq: got %h/%h expected 0/0", creq_addr, creq_len); end
    @(negedge clk); resetn = 1'b1;
    @(negedge clk); #1;
    checks++; if ({addr_ok, data_ok, inv_done, creq_valid} !== 4'b0) begin
      errors++; $display("FAIL post_reset_flags: got %b expected 0000", {addr_ok, data_ok, inv_done, creq_valid}); end
  endtask

  task automatic test_miss();
    fetch(32'h1000, 32'hA0, s_req, s_addr, s_len, s_lat, s_ok, s_data, s_tmo);
    checks++; if (s_req !== 1'b1) begin errors++; $display("FAIL miss_creq: got %b expected 1", s_req); end
    checks++; if (s_addr !== 32'h1000) begin errors++; $display("FAIL miss_creq_addr: got %h expected 00001000", s_addr); end
    checks++; if (s_len !== 4'd7) begin errors++; $display("FAIL miss_creq_len: got %0d expected 7", s_len); end
    checks++; if (s_lat !== 1) begin errors++; $display("FAIL miss_addr_ok_latency: got %0d expected 1", s_lat); end
    checks++; if (s_ok !== 1'b1) begin errors++; $display("FAIL miss_data_ok: got %b expected 1", s_ok); end
    checks++; if (s_data !== 32'hA0) begin errors++; $display("FAIL miss_rdata: got %h expected 000000a0", s_data); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    for (int i = 0; i <= WPL; i++) begin
      if (i < WPL) begin req_valid = 1'b1; req_addr = 32'h1000 + 32'(4 * i); end
      else req_valid = 1'b0;
      #1;
      if (i > 0) begin
        checks++; if (data_ok !== 1'b1 || rdata !== 32'hA0 + 32'(i - 1)) begin
          errors++; $display("FAIL b2b_data[%0d]: got %b/%h expected 1/%h", i - 1, data_ok, rdata, 32'hA0 + 32'(i - 1)); end
      end
      if (i < WPL) begin
        checks++; if (addr_ok !== 1'b1 || creq_valid !== 1'b0) begin
          errors++; $display("FAIL b2b_accept[%0d]: got addr_ok=%b creq_valid=%b expected 1/0", i, addr_ok, creq_valid); end
      end
      @(negedge clk);
    end
    #1;
    checks++; if (data_ok !== 1'b0) begin errors++; $display("FAIL b2b_extra_data_ok: got %b expected 0", data_ok); end
  endtask

  task automatic test_hit_invalidate();
    @(negedge clk);
    inv_valid = 1'b1; inv_hit = 1'b1; inv_addr = 32'h1000; req_valid = 1'b1; req_addr = 32'h1000;
    #1;
    checks++; if (inv_done !== 1'b1 || addr_ok !== 1'b0) begin
      errors++; $display("FAIL inv_concurrent: got inv_done=%b addr_ok=%b expected 1/0", inv_done, addr_ok); end
    @(negedge clk);
    inv_valid = 1'b0;
    #1;
    checks++; if (inv_done !== 1'b0 || addr_ok !== 1'b0) begin
      errors++; $display("FAIL inv_after: got inv_done=%b addr_ok=%b expected 0/0", inv_done, addr_ok); end
    fetch(32'h1000, 32'hB0, s_req, s_addr, s_len, s_lat, s_ok, s_data, s_tmo);
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h1000) begin
      errors++; $display("FAIL inv_refetch_miss: got %b/%h expected 1/00001000", s_req, s_addr); end
    checks++; if (s_ok !== 1'b1 || s_data !== 32'hB0) begin
      errors++; $display("FAIL inv_refetch_data: got %b/%h expected 1/000000b0", s_ok, s_data); end
  endtask

  task automatic test_reset_mid_refill();
    logic got;
    got = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h3000;
    for (int c = 0; c < 10 && !got; c++) begin
      #1;
      if (creq_valid) got = 1'b1; else @(negedge clk);
    end
    checks++; if (got !== 1'b1 || creq_addr !== 32'h3000) begin
      errors++; $display("FAIL mid_refill_start: got %b/%h expected 1/00003000", got, creq_addr); end
    for (int b = 0; b < 3; b++) begin
      cresp_ready = 1'b1; cresp_data = 32'hC0 + 32'(b); cresp_last = 1'b0;
      @(negedge clk); #1;
    end
    cresp_ready = 1'b0;
    resetn = 1'b0;
    #1;
    checks++; if (creq_valid !== 1'b0 || creq_addr !== 32'h0) begin
      errors++; $display("FAIL mid_refill_abort: got %b/%h expected 0/0", creq_valid, creq_addr); end
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    fetch(32'h3000, 32'hD0, s_req, s_addr, s_len, s_lat, s_ok, s_data, s_tmo);
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h3000) begin
      errors++; $display("FAIL mid_refill_remiss: got %b/%h expected 1/00003000", s_req, s_addr); end
    checks++; if (s_ok !== 1'b1 || s_data !== 32'hD0) begin
      errors++; $display("FAIL mid_refill_data: got %b/%h expected 1/000000d0", s_ok, s_data); end
  endtask

  task automatic test_index_invalidate();
    logic [31:0] inv_list [3];
    logic [1:0]  seen;
    inv_list[0] = 32'h0000_00A0;  // index mode, set 5 way 0 (empty)
    inv_list[1] = 32'h0000_0800;  // index mode, set 0 way 1 (empty)
    inv_list[2] = 32'h0000_7000;  // hit mode, absent tag
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      inv_valid = 1'b1; inv_hit = (k == 2); inv_addr = inv_list[k];
      #1;
      seen[0] = inv_done;
      @(negedge clk);
      inv_valid = 1'b0;
      #1;
      seen[1] = inv_done;
      checks++; if (seen !== 2'b01) begin
        errors++; $display("FAIL inv_pulse[%0d]: got %b expected 01", k, seen); end
    end
    fetch(32'h3004, 32'hF0, s_req, s_addr, s_len, s_lat, s_ok, s_data, s_tmo);
    checks++; if (s_req !== 1'b0 || s_ok !== 1'b1 || s_data !== 32'hD1) begin
      errors++; $display("FAIL inv_noop_hit: got creq=%b ok=%b data=%h expected 0/1/000000d1", s_req, s_ok, s_data); end
    @(negedge clk);
    inv_valid = 1'b1; inv_hit = 1'b0; inv_addr = 32'h0000_0000;
    @(negedge clk);
    inv_valid = 1'b0;
    fetch(32'h3000, 32'hE0, s_req, s_addr, s_len, s_lat, s_ok, s_data, s_tmo);
    checks++; if (s_req !== 1'b1 || s_data !== 32'hE0) begin
      errors++; $display("FAIL inv_index_kill: got creq=%b data=%h expected 1/000000e0", s_req, s_data); end
  endtask

  task automatic test_plru();
    logic [31:0] addrs [5];
    logic        exp_miss [6];
    logic [31:0] exp_data [6];
    int          order [6];
    apply_reset();
    for (int i = 0; i < 5; i++) addrs[i] = 32'(i) * 32'h800;
    for (int i = 0; i < 4; i++) begin
      fetch(addrs[i], 32'h100 * 32'(i + 1), s_req, s_addr, s_len, s_lat, s_ok, s_data, s_tmo);
      checks++; if (s_req !== 1'b1 || s_data !== 32'h100 * 32'(i + 1)) begin
        errors++; $display("FAIL plru_fill[%0d]: got creq=%b data=%h expected 1/%h", i, s_req, s_data, 32'h100 * 32'(i + 1)); end
    end
    // touch A, fetch E, then probe A, C, D, E (hits) and B (evicted)
    order = '{0, 4, 0, 2, 3, 1};
    exp_miss = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_data = '{32'h100, 32'h500, 32'h100, 32'h300, 32'h400, 32'h600};
    for (int j = 0; j < 6; j++) begin
      fetch(addrs[order[j]], exp_data[j], s_req, s_addr, s_len, s_lat, s_ok, s_data, s_tmo);
      checks++; if (s_req !== exp_miss[j] || s_ok !== 1'b1 || s_data !== exp_data[j]) begin
        errors++; $display("FAIL plru_step[%0d]: got creq=%b ok=%b data=%h expected %b/1/%h", j, s_req, s_ok, s_data, exp_miss[j], exp_data[j]); end
    end
  endtask

  initial begin
    test_reset();
    test_miss();
    test_back_to_back();
    test_hit_invalidate();
    test_reset_mid_refill();
    test_index_invalidate();
    test_plru();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
